axis_mem_reader: RTL

- Read-side counterpart of the stream-to-memory write path: accepts a read command (start address, word count) on an AXI-Stream slave port.
- Fetches the words from a synchronous single-port RAM read port and emits them as one AXI-Stream master packet, with tlast on the final word.
- Sits between the memory and the downstream stream consumer.
- Sustains one word per cycle and tolerates arbitrary backpressure without losing or duplicating data.

---
 rtl/axis_pkg.sv | 14 +
 rtl/axis_skid_fifo.sv | 48 ++++
 rtl/axis_mem_reader.sv | 116 +++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared types for the stream/memory bridge blocks: reader state encoding
// and the bit offsets of the fields inside a read command word.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } reader_state_e;

    localparam int CMD_ADDR_LSB = 0;
    localparam int CMD_LEN_LSB  = 16;

endpackage

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO with fall-through: a push into an empty FIFO is visible at
// the head in the same cycle, so a simultaneous push/pop on empty stores nothing.
module axis_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slots [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_write;
    logic             do_read;

    assign empty      = (count == 2'd0);
    assign full       = (count == 2'd2);
    assign head_valid = !empty || push;
    assign head_data  = empty ? push_data : slots[rd_ptr];
    assign do_read    = pop && !empty;
    assign do_write   = push && !(pop && empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_write) wr_ptr <= ~wr_ptr;
            if (do_read)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_write} - {1'b0, do_read};
        end
    end

    // Storage carries no reset; occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (do_write) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axis_mem_reader.sv
// Turns a {length, address} command into a memory read burst and streams the
// returned words out as one packet, holding at most two words in flight or buffered.
module axis_mem_reader
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                              m01_axis_aclk,
    input  logic                              m01_axis_aresetn,
    input  logic [CMD_LEN_LSB+LEN_WIDTH-1:0]  s01_axis_tdata,
    input  logic                              s01_axis_tvalid,
    output logic                              s01_axis_tready,
    output logic                              mem_rd_en,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic [DATA_WIDTH-1:0]             m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]           m01_axis_tstrb,
    output logic                              m01_axis_tvalid,
    output logic                              m01_axis_tlast,
    input  logic                              m01_axis_tready,
    output logic                              busy,
    output reader_state_e                     dbg_state
);

    // Stream handshake: a beat transfers on the rising edge where tvalid and
    // tready are both high; tvalid never depends on tready, and payload holds
    // steady while tvalid is high and tready is low.

    reader_state_e            state;
    reader_state_e            state_next;
    logic [ADDR_WIDTH-1:0]    cur_addr;
    logic [LEN_WIDTH:0]       total;
    logic [LEN_WIDTH:0]       issued;
    logic                     inflight;
    logic                     inflight_last;
    logic                     cmd_fire;
    logic                     issue;
    logic                     issue_last;
    logic                     beat_fire;
    logic [DATA_WIDTH:0]      fifo_head;
    logic                     fifo_head_valid;
    logic [1:0]               fifo_count;
    logic                     unused_fifo_full;
    logic                     unused_fifo_empty;
    logic                     unused_cmd_bits;

    assign unused_cmd_bits = ^s01_axis_tdata;

    assign s01_axis_tready = m01_axis_aresetn && (state == IDLE);
    assign cmd_fire        = s01_axis_tvalid && s01_axis_tready;
    // Credit: words buffered plus the one read in flight never exceed two.
    assign issue           = (state == READ) && (issued < total)
                             && ((fifo_count + {1'b0, inflight}) < 2'd2);
    assign issue_last      = (issued == total - (LEN_WIDTH+1)'(1));
    assign beat_fire       = fifo_head_valid && m01_axis_tready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = READ;
            READ:    if (issue && issue_last) state_next = DRAIN;
            DRAIN:   if (beat_fire && fifo_head[DATA_WIDTH]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m01_axis_aclk or negedge m01_axis_aresetn) begin
        if (!m01_axis_aresetn) begin
            state         <= IDLE;
            cur_addr      <= '0;
            total         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_next;
            inflight      <= issue;
            inflight_last <= issue && issue_last;
            if (cmd_fire) begin
                cur_addr <= s01_axis_tdata[CMD_ADDR_LSB +: ADDR_WIDTH];
                total    <= {1'b0, s01_axis_tdata[CMD_LEN_LSB +: LEN_WIDTH]} + (LEN_WIDTH+1)'(1);
                issued   <= '0;
            end else if (issue) begin
                cur_addr <= cur_addr + ADDR_WIDTH'(1);
                issued   <= issued + (LEN_WIDTH+1)'(1);
            end
        end
    end

    axis_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk        (m01_axis_aclk),
        .rst_n      (m01_axis_aresetn),
        .push       (inflight),
        .push_data  ({inflight_last, mem_rdata}),
        .pop        (beat_fire),
        .head_data  (fifo_head),
        .head_valid (fifo_head_valid),
        .full       (unused_fifo_full),
        .empty      (unused_fifo_empty),
        .count      (fifo_count)
    );

    assign mem_rd_en       = issue;
    assign mem_addr        = issue ? cur_addr : '0;
    assign m01_axis_tvalid = fifo_head_valid;
    assign m01_axis_tdata  = fifo_head_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign m01_axis_tlast  = fifo_head_valid && fifo_head[DATA_WIDTH];
    assign m01_axis_tstrb  = {(DATA_WIDTH/8){fifo_head_valid}};
    assign busy            = (state != IDLE);
    assign dbg_state       = state;

endmodule
